// File: rtl/fir_fold_sequencer.sv
// Control sequencer for a folded FIR: accepts a sample, steps the tap group over FOLD MAC cycles,
// then holds the result until it is taken downstream. Macro LOW_POWER_CG_EN enables MAC clock gating.
module fir_fold_sequencer #(
  parameter  int N_TAPS = 8,
  parameter  int FOLD   = 4,
  localparam int SEL_W  = $clog2(FOLD)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             shift_en,
  output logic [SEL_W-1:0] tap_sel,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             mac_clk_en
);

  // state | meaning
  // IDLE  | waiting for a sample; in_ready high (from the cycle after reset release)
  // MAC   | FOLD accumulate cycles, tap_sel 0..FOLD-1, acc_clr on the first
  // HOLD  | result valid in the accumulator, waiting for out_ready

  generate
    if ((N_TAPS % FOLD) != 0 || FOLD < 2) begin : g_bad_cfg
      $error("fir_fold_sequencer: N_TAPS must be a multiple of FOLD and FOLD >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(FOLD - 1);

  state_t           state, state_nxt;
  logic             in_ready_nxt;
  logic [SEL_W-1:0] tap_sel_nxt;
  logic             acc_clr_nxt;
  logic             acc_en_nxt;
  logic             out_valid_nxt;

  assign shift_en = in_valid & in_ready;

`ifdef LOW_POWER_CG_EN
  assign mac_clk_en = shift_en | acc_en;
`else
  assign mac_clk_en = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      tap_sel   <= '0;
      acc_clr   <= 1'b0;
      acc_en    <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= in_ready_nxt;
      tap_sel   <= tap_sel_nxt;
      acc_clr   <= acc_clr_nxt;
      acc_en    <= acc_en_nxt;
      out_valid <= out_valid_nxt;
      busy      <= (state_nxt != S_IDLE);
    end
  end

  always_comb begin
    state_nxt     = state;
    in_ready_nxt  = in_ready;
    tap_sel_nxt   = tap_sel;
    acc_clr_nxt   = 1'b0;
    acc_en_nxt    = acc_en;
    out_valid_nxt = out_valid;
    case (state)
      S_IDLE: begin
        if (shift_en) begin
          state_nxt    = S_MAC;
          in_ready_nxt = 1'b0;
          tap_sel_nxt  = '0;
          acc_clr_nxt  = 1'b1;
          acc_en_nxt   = 1'b1;
        end else begin
          in_ready_nxt = 1'b1;
        end
      end
      S_MAC: begin
        if (tap_sel == LAST_SEL) begin
          state_nxt     = S_HOLD;
          tap_sel_nxt   = '0;
          acc_en_nxt    = 1'b0;
          out_valid_nxt = 1'b1;
        end else begin
          tap_sel_nxt = tap_sel + SEL_W'(1);
        end
      end
      S_HOLD: begin
        if (out_valid && out_ready) begin
          state_nxt     = S_IDLE;
          out_valid_nxt = 1'b0;
          in_ready_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fir_fold_sequencer.sv
// Self-checking bench for fir_fold_sequencer: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a cycle-count model of the schedule.
module tb_fir_fold_sequencer;
  localparam int FOLD   = 4;
  localparam int N_TAPS = 8;
  localparam int SEL_W  = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic             in_ready, shift_en, acc_clr, acc_en, out_valid, busy, mac_clk_en;
  logic [SEL_W-1:0] tap_sel;

  fir_fold_sequencer #(.N_TAPS(N_TAPS), .FOLD(FOLD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .shift_en(shift_en),
    .tap_sel(tap_sel), .acc_clr(acc_clr), .acc_en(acc_en), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .mac_clk_en(mac_clk_en)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

`ifdef LOW_POWER_CG_EN
  localparam bit CG = 1'b1;
`else
  localparam bit CG = 1'b0;
`endif

  // Model: m_k = cycles since the sample was accepted while accumulating (0 = none),
  // m_hold = a finished result is waiting, m_rdy = sequencer will accept this cycle.
  bit m_known = 1'b0;
  bit m_rdy = 1'b0;
  bit m_hold = 1'b0;
  int m_k = 0;

  logic s_in_ready, s_shift_en, s_acc_clr, s_acc_en, s_out_valid, s_busy, s_mac_clk_en;
  logic [SEL_W-1:0] s_tap_sel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic iv, input logic ordy, input logic rs);
    logic e_shift;
    @(negedge clk);
    in_valid  = iv;
    out_ready = ordy;
    rst       = rs;
    #1;
    s_in_ready   = in_ready;
    s_shift_en   = shift_en;
    s_tap_sel    = tap_sel;
    s_acc_clr    = acc_clr;
    s_acc_en     = acc_en;
    s_out_valid  = out_valid;
    s_busy       = busy;
    s_mac_clk_en = mac_clk_en;
    e_shift = iv & m_rdy;
    if (m_known) begin
      chk("m_in_ready",  32'(s_in_ready),  32'(m_rdy));
      chk("m_shift_en",  32'(s_shift_en),  32'(e_shift));
      chk("m_tap_sel",   32'(s_tap_sel),   (m_k > 0) ? 32'(m_k - 1) : 32'd0);
      chk("m_acc_clr",   32'(s_acc_clr),   32'(m_k == 1));
      chk("m_acc_en",    32'(s_acc_en),    32'(m_k > 0));
      chk("m_out_valid", 32'(s_out_valid), 32'(m_hold));
      chk("m_busy",      32'(s_busy),      32'((m_k > 0) || m_hold));
      chk("m_mac_clk_en", 32'(s_mac_clk_en), CG ? 32'(e_shift | (m_k > 0)) : 32'd1);
    end
    @(posedge clk);
    if (rs) begin
      m_known = 1'b1;
      m_rdy = 1'b0;
      m_hold = 1'b0;
      m_k = 0;
    end else if (m_hold) begin
      if (ordy) begin
        m_hold = 1'b0;
        m_rdy = 1'b1;
      end
    end else if (m_k > 0) begin
      if (m_k == FOLD) begin
        m_k = 0;
        m_hold = 1'b1;
      end else begin
        m_k++;
      end
    end else if (e_shift) begin
      m_k = 1;
      m_rdy = 1'b0;
    end else begin
      m_rdy = 1'b1;
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_in_ready"},  32'(s_in_ready),  32'd0);
    chk({name, "_tap_sel"},   32'(s_tap_sel),   32'd0);
    chk({name, "_acc_clr"},   32'(s_acc_clr),   32'd0);
    chk({name, "_acc_en"},    32'(s_acc_en),    32'd0);
    chk({name, "_out_valid"}, 32'(s_out_valid), 32'd0);
    chk({name, "_busy"},      32'(s_busy),      32'd0);
  endtask

  initial begin
    int mc;
    int n_shift, n_clr, n_xfer;

    // reset held for 3 cycles
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    chk_all_zero("rst2");
    cycle(0, 0, 1);
    chk_all_zero("rst3");
    if (!CG) chk("rst_mac_clk_en", 32'(s_mac_clk_en), 32'd1);
    cycle(0, 0, 0);
    chk("release_in_ready", 32'(s_in_ready), 32'd0);
    cycle(0, 0, 0);
    chk("after_release_in_ready", 32'(s_in_ready), 32'd1);

    // single sample with out_ready high
    mc = 0;
    cycle(1, 1, 0);
    chk("single_shift_T", 32'(s_shift_en), 32'd1);
    mc += int'(s_mac_clk_en);
    for (int i = 1; i <= 4; i++) begin
      cycle(0, 1, 0);
      chk("single_tap_sel", 32'(s_tap_sel), 32'(i - 1));
      chk("single_acc_clr", 32'(s_acc_clr), 32'(i == 1));
      chk("single_acc_en",  32'(s_acc_en),  32'd1);
      mc += int'(s_mac_clk_en);
    end
    cycle(0, 1, 0);
    chk("single_out_valid_T5", 32'(s_out_valid), 32'd1);
    mc += int'(s_mac_clk_en);
    cycle(0, 0, 0);
    chk("single_out_valid_T6", 32'(s_out_valid), 32'd0);
    chk("single_in_ready_T6",  32'(s_in_ready),  32'd1);
    mc += int'(s_mac_clk_en);
    chk("single_mac_clk_cycles", 32'(mc), CG ? 32'd5 : 32'd7);

    // backpressure T+5..T+7, accept at T+8
    cycle(1, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0);
    for (int i = 5; i <= 7; i++) begin
      cycle(1, 0, 0);
      chk("bp_out_valid", 32'(s_out_valid), 32'd1);
      chk("bp_acc_en",    32'(s_acc_en),    32'd0);
      chk("bp_in_ready",  32'(s_in_ready),  32'd0);
      chk("bp_shift_en",  32'(s_shift_en),  32'd0);
    end
    cycle(0, 1, 0);
    chk("bp_out_valid_T8", 32'(s_out_valid), 32'd1);
    cycle(0, 0, 0);
    chk("bp_out_valid_T9", 32'(s_out_valid), 32'd0);
    chk("bp_in_ready_T9",  32'(s_in_ready),  32'd1);

    // streaming for 30 cycles
    n_shift = 0; n_clr = 0; n_xfer = 0;
    for (int i = 0; i < 30; i++) begin
      cycle(1, 1, 0);
      n_shift += int'(s_shift_en);
      n_clr   += int'(s_acc_clr);
      n_xfer  += int'(s_out_valid);
    end
    chk("stream_shift_count", 32'(n_shift), 32'd5);
    chk("stream_out_count",   32'(n_xfer),  32'd5);
    chk("stream_clr_vs_out",  32'(n_clr),   32'(n_xfer));

    // abort with reset while tap_sel = 2
    cycle(1, 1, 0);
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    cycle(0, 1, 1);
    chk("abort_tap_sel_before", 32'(s_tap_sel), 32'd2);
    cycle(0, 1, 0);
    chk_all_zero("abort");
    cycle(0, 1, 0);
    chk("abort_in_ready", 32'(s_in_ready), 32'd1);
    cycle(1, 1, 0);
    chk("abort_new_shift", 32'(s_shift_en), 32'd1);
    cycle(0, 1, 0);
    chk("abort_new_tap_sel", 32'(s_tap_sel), 32'd0);
    chk("abort_new_acc_clr", 32'(s_acc_clr), 32'd1);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0);
    cycle(0, 1, 0);
    chk("abort_new_out_valid", 32'(s_out_valid), 32'd1);

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 63) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
